// File: rtl/muldiv_pkg.sv
// Shared constants, FSM state encoding and RV32M funct3 opcodes for the
// sequential multiply/divide unit.
package muldiv_pkg;

  localparam int MD_XLEN  = 32;
  localparam int MD_ITERS = 32;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREP,
    S_CALC,
    S_FIX,
    S_DONE
  } state_e;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the sequential datapath: shift-add for multiply,
// restoring shift-subtract for divide, on a {hi, lo} register pair.
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int XLEN = MD_XLEN
) (
  input  logic            i_div,
  input  logic [XLEN-1:0] i_hi,
  input  logic [XLEN-1:0] i_lo,
  input  logic [XLEN-1:0] i_opnd,
  output logic [XLEN-1:0] o_hi,
  output logic [XLEN-1:0] o_lo
);

  logic [XLEN:0]   w_add;
  logic [XLEN:0]   w_shift;
  logic [XLEN+1:0] w_sub;
  logic            w_fits;

  assign w_add   = {1'b0, i_hi} + {1'b0, i_opnd};
  assign w_shift = {i_hi, i_lo[XLEN-1]};
  assign w_sub   = {1'b0, w_shift} - {2'b00, i_opnd};
  // A successful subtract never borrows and always leaves a remainder below the divisor.
  assign w_fits  = (w_sub[XLEN+1:XLEN] == 2'b00);

  always_comb begin
    o_hi = i_hi;
    o_lo = i_lo;
    if (i_div) begin
      if (w_fits) begin
        o_hi = w_sub[XLEN-1:0];
        o_lo = {i_lo[XLEN-2:0], 1'b1};
      end else begin
        o_hi = w_shift[XLEN-1:0];
        o_lo = {i_lo[XLEN-2:0], 1'b0};
      end
    end else if (i_lo[0]) begin
      {o_hi, o_lo} = {w_add, i_lo[XLEN-1:1]};
    end else begin
      {o_hi, o_lo} = {1'b0, i_hi, i_lo[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_seq.sv
// Iterative RV32M multiply/divide unit: capture, sign prep, 32 iteration
// cycles, sign fix-up and a one-cycle result pulse.
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int XLEN = MD_XLEN
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            valid_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  input  logic            flush_i,
  output logic            ready_o,
  output logic            busy_o,
  output logic            valid_o,
  output logic [XLEN-1:0] result_o
);

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_e            r_state;
  state_e            w_next;
  logic [2:0]        r_funct3;
  logic [XLEN-1:0]   r_rs1;
  logic [XLEN-1:0]   r_rs2;
  logic [XLEN-1:0]   r_hi;
  logic [XLEN-1:0]   r_lo;
  logic [XLEN-1:0]   r_opnd;
  logic [XLEN-1:0]   r_result;
  logic [31:0]       r_cnt;
  logic              r_neg;
  logic              r_sign_a;

  logic              w_accept;
  logic              w_load_result;
  logic              w_is_div;
  logic              w_sign_a;
  logic              w_sign_b;
  logic              w_div_zero;
  logic              w_ovf;
  logic [XLEN-1:0]   w_abs1;
  logic [XLEN-1:0]   w_abs2;
  logic [XLEN-1:0]   w_special_res;
  logic [XLEN-1:0]   w_fix_res;
  logic [XLEN-1:0]   w_result_sel;
  logic [XLEN-1:0]   w_step_hi;
  logic [XLEN-1:0]   w_step_lo;
  logic [XLEN-1:0]   w_quot_fix;
  logic [XLEN-1:0]   w_rem_fix;
  logic [2*XLEN-1:0] w_prod_fix;

  assign ready_o  = (r_state == S_IDLE);
  assign busy_o   = (r_state != S_IDLE);
  assign valid_o  = (r_state == S_DONE);
  assign result_o = r_result;

  assign w_is_div   = r_funct3[2];
  assign w_sign_a   = r_rs1[XLEN-1] && (r_funct3 inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM});
  assign w_sign_b   = r_rs2[XLEN-1] && (r_funct3 inside {OP_MULH, OP_DIV, OP_REM});
  assign w_abs1     = w_sign_a ? (~r_rs1 + 1'b1) : r_rs1;
  assign w_abs2     = w_sign_b ? (~r_rs2 + 1'b1) : r_rs2;
  assign w_div_zero = w_is_div && (r_rs2 == '0);
  assign w_ovf      = (r_funct3 == OP_DIV || r_funct3 == OP_REM) &&
                      (r_rs1 == MIN_NEG) && (r_rs2 == '1);

  // funct3[1] separates the remainder ops from the quotient ops.
  always_comb begin
    w_special_res = '1;
    if (w_div_zero) begin
      w_special_res = r_funct3[1] ? r_rs1 : '1;
    end else if (w_ovf) begin
      w_special_res = r_funct3[1] ? '0 : MIN_NEG;
    end
  end

  assign w_prod_fix = r_neg ? (~{r_hi, r_lo} + 1'b1) : {r_hi, r_lo};
  assign w_quot_fix = r_neg ? (~r_lo + 1'b1) : r_lo;
  assign w_rem_fix  = r_sign_a ? (~r_hi + 1'b1) : r_hi;

  always_comb begin
    w_fix_res = w_rem_fix;
    case (r_funct3)
      OP_MUL:                       w_fix_res = w_prod_fix[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: w_fix_res = w_prod_fix[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:              w_fix_res = w_quot_fix;
      default:                      w_fix_res = w_rem_fix;
    endcase
  end

  muldiv_step #(.XLEN(XLEN)) u_step (
    .i_div  (w_is_div),
    .i_hi   (r_hi),
    .i_lo   (r_lo),
    .i_opnd (r_opnd),
    .o_hi   (w_step_hi),
    .o_lo   (w_step_lo)
  );

  always_comb begin
    w_next        = r_state;
    w_accept      = 1'b0;
    w_load_result = 1'b0;
    w_result_sel  = r_result;
    case (r_state)
      S_IDLE: begin
        if (valid_i) begin
          w_accept = 1'b1;
          w_next   = S_PREP;
        end
      end
      S_PREP: begin
        if (w_div_zero || w_ovf) begin
          w_next        = S_DONE;
          w_load_result = 1'b1;
          w_result_sel  = w_special_res;
        end else begin
          w_next = S_CALC;
        end
      end
      S_CALC: begin
        if (r_cnt == 32'(MD_ITERS - 1)) w_next = S_FIX;
      end
      S_FIX: begin
        w_next        = S_DONE;
        w_load_result = 1'b1;
        w_result_sel  = w_fix_res;
      end
      default: w_next = S_IDLE;
    endcase
    // Flush aborts everything; DONE already drives valid_o this cycle.
    if (flush_i) begin
      w_next        = S_IDLE;
      w_accept      = 1'b0;
      w_load_result = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_funct3 <= '0;
      r_rs1    <= '0;
      r_rs2    <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_opnd   <= '0;
      r_result <= '0;
      r_cnt    <= '0;
      r_neg    <= 1'b0;
      r_sign_a <= 1'b0;
    end else begin
      if (w_accept) begin
        r_funct3 <= funct3_i;
        r_rs1    <= rs1_i;
        r_rs2    <= rs2_i;
      end
      if (w_load_result) r_result <= w_result_sel;
      if (r_state == S_PREP) begin
        r_cnt    <= '0;
        r_hi     <= '0;
        r_sign_a <= w_sign_a;
        r_neg    <= w_sign_a ^ w_sign_b;
        // lo holds the multiplier or dividend; opnd the multiplicand or divisor.
        r_lo     <= w_is_div ? w_abs1 : w_abs2;
        r_opnd   <= w_is_div ? w_abs2 : w_abs1;
      end else if (r_state == S_CALC) begin
        r_hi  <= w_step_hi;
        r_lo  <= w_step_lo;
        r_cnt <= r_cnt + 32'd1;
      end
    end
  end

endmodule
